// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - MIPS opcode/funct constants, register ids and sequencer types
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_ISSUE,
        ST_WAIT_RES,
        ST_WRITE
    } rf_state_t;

    // Instruction fields the sequencer needs; shamt and the immediate are not kept.
    typedef struct packed {
        logic [5:0] opcode;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic [5:0] funct;
    } instr_fields_t;

endpackage

// File: rtl/rf_dest_decode.sv
// rtl/rf_dest_decode.sv - maps an instruction to {writes, destination register}
//   opcode/rt/rd/funct : instruction fields
//   writes             : instruction produces a register write-back
//   dest               : destination register (rd for R-type, 31 for jal, rt otherwise)
module rf_dest_decode
    import mips_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic [5:0]        opcode,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [5:0]        funct,
    output logic              writes,
    output logic [ADDR_W-1:0] dest
);

    always_comb begin
        writes = 1'b0;
        dest   = ADDR_W'(rt);
        case (opcode)
            OP_RTYPE: begin
                writes = (funct != FN_JR);
                dest   = ADDR_W'(rd);
            end
            OP_JAL: begin
                writes = 1'b1;
                dest   = ADDR_W'(REG_RA);
            end
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI, OP_LW: begin
                writes = 1'b1;
            end
            OP_SW, OP_BEQ, OP_BNE, OP_J: begin
                writes = 1'b0;
            end
            default: begin
                writes = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/rf_access_ctrl.sv
// rtl/rf_access_ctrl.sv - register file read/operand issue/write-back sequencer
//   CLK/RST                   : clock, synchronous active-high reset
//   INSTR_VALID/READY, INSTR  : instruction intake, accepted only in IDLE
//   RFRA1/2, RFRD1/2          : register file read port (rs, rt)
//   OPS_VALID/READY, OPA/OPB  : operands to execute
//   RES_VALID/READY, RES_DATA : result from execute
//   RFWE/RFWA/RFWD            : registered write-back port
module rf_access_ctrl
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              INSTR_VALID,
    output logic              INSTR_READY,
    input  logic [31:0]       INSTR,
    output logic [ADDR_W-1:0] RFRA1,
    output logic [ADDR_W-1:0] RFRA2,
    input  logic [DATA_W-1:0] RFRD1,
    input  logic [DATA_W-1:0] RFRD2,
    output logic              OPS_VALID,
    input  logic              OPS_READY,
    output logic [DATA_W-1:0] OPA,
    output logic [DATA_W-1:0] OPB,
    input  logic              RES_VALID,
    output logic              RES_READY,
    input  logic [DATA_W-1:0] RES_DATA,
    output logic              RFWE,
    output logic [ADDR_W-1:0] RFWA,
    output logic [DATA_W-1:0] RFWD
);

    rf_state_t     state_q, state_d;
    instr_fields_t instr_q, instr_d;
    logic [DATA_W-1:0] opa_q, opa_d;
    logic [DATA_W-1:0] opb_q, opb_d;
    logic              rfwe_q, rfwe_d;
    logic [ADDR_W-1:0] rfwa_q, rfwa_d;
    logic [DATA_W-1:0] rfwd_q, rfwd_d;

    logic              dest_writes;
    logic [ADDR_W-1:0] dest_reg;

    // shamt plays no part in operand fetch or write-back
    logic unused_shamt;
    assign unused_shamt = ^INSTR[10:6];

    rf_dest_decode #(
        .ADDR_W (ADDR_W)
    ) u_dest_decode (
        .opcode (instr_q.opcode),
        .rt     (instr_q.rt),
        .rd     (instr_q.rd),
        .funct  (instr_q.funct),
        .writes (dest_writes),
        .dest   (dest_reg)
    );

    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        rfwe_d      = 1'b0;
        rfwa_d      = rfwa_q;
        rfwd_d      = rfwd_q;
        INSTR_READY = 1'b0;
        OPS_VALID   = 1'b0;
        RES_READY   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                INSTR_READY = 1'b1;
                if (INSTR_VALID) begin
                    instr_d = '{opcode: INSTR[31:26], rs: INSTR[25:21], rt: INSTR[20:16],
                                rd: INSTR[15:11], funct: INSTR[5:0]};
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                // The register file does not hardwire $0, so mask it here.
                opa_d   = (instr_q.rs == REG_ZERO) ? '0 : RFRD1;
                opb_d   = (instr_q.rt == REG_ZERO) ? '0 : RFRD2;
                state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                OPS_VALID = 1'b1;
                if (OPS_READY) begin
                    state_d = ST_WAIT_RES;
                end
            end
            ST_WAIT_RES: begin
                RES_READY = 1'b1;
                if (RES_VALID) begin
                    rfwa_d = dest_reg;
                    rfwd_d = RES_DATA;
                    // A write to $0 is swallowed: result accepted, no write-back cycle.
                    if (dest_writes && (dest_reg != '0)) begin
                        rfwe_d  = 1'b1;
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            instr_q <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            rfwe_q  <= 1'b0;
            rfwa_q  <= '0;
            rfwd_q  <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            rfwe_q  <= rfwe_d;
            rfwa_q  <= rfwa_d;
            rfwd_q  <= rfwd_d;
        end
    end

    assign RFRA1 = ADDR_W'(instr_q.rs);
    assign RFRA2 = ADDR_W'(instr_q.rt);
    assign OPA   = opa_q;
    assign OPB   = opb_q;
    assign RFWE  = rfwe_q;
    assign RFWA  = rfwa_q;
    assign RFWD  = rfwd_q;

endmodule

// File: doc/rf_access_ctrl.md
# rf_access_ctrl

Sequencing initiator for the multicycle datapath's register file: accepts one instruction word, drives the register file read addresses, and captures operands into A/B registers. It hands operands to the execute stage, waits for the result, then issues exactly one write-back transaction (RFWE/RFWA/RFWD). It also enforces MIPS `$0` semantics, since the register file itself does not hardwire register 0.

## Interface
Parameters:
- DATA_W, 32, datapath and register width
- ADDR_W, 5, register address width

Ports:
- CLK  in  1  system clock; all state updates on rising edge
- RST  in  1  reset; synchronous, active-high
- INSTR_VALID  in  1  instruction word offered
- INSTR_READY  out  1  block can accept an instruction; high only in IDLE
- INSTR  in  32  MIPS instruction word
- RFRA1  out  ADDR_W  read address 1 = latched rs (bits 25:21)
- RFRA2  out  ADDR_W  read address 2 = latched rt (bits 20:16)
- RFRD1  in  DATA_W  combinational read data 1 from the register file
- RFRD2  in  DATA_W  combinational read data 2 from the register file
- OPS_VALID  out  1  OPA/OPB valid for execute
- OPS_READY  in  1  execute accepts operands
- OPA  out  DATA_W  registered operand A
- OPB  out  DATA_W  registered operand B
- RES_VALID  in  1  execute result offered
- RES_READY  out  1  high only in WAIT_RES
- RES_DATA  in  DATA_W  result to write back
- RFWE  out  1  register file write enable, registered
- RFWA  out  ADDR_W  write address, registered
- RFWD  out  DATA_W  write data, registered

## Operation
- FSM states and transitions:
  - IDLE: on INSTR_VALID&&INSTR_READY, latch INSTR and go to READ.
  - READ: drive RFRA1/RFRA2 from the latched instruction; at the end of the cycle latch OPA←(rs==0 ? 0 : RFRD1) and OPB←(rt==0 ? 0 : RFRD2); go to ISSUE.
  - ISSUE: OPS_VALID=1; on OPS_READY go to WAIT_RES.
  - WAIT_RES: RES_READY=1; on RES_VALID go to WRITE if the instruction writes, else go to IDLE.
  - WRITE: RFWE=1 for exactly one cycle; go to IDLE.
- Destination decode:
  - opcode 0x00 → rd (bits 15:11)
  - opcode 0x03 (jal) → 31
  - all other writing opcodes → rt
- Writing instructions:
  - R-type except funct 0x08 (jr)
  - opcodes 0x08, 0x0A, 0x0C, 0x0D, 0x0F, 0x23, 0x03
  - All others (sw, beq, bne, j, unknown opcodes) never assert RFWE.
- Destination 0 suppresses the write: the result is still accepted, with no RFWE.
- RFWA/RFWD are loaded from the decoded destination and RES_DATA on the RES handshake. They hold their values afterwards; only RFWE qualifies them.
- Inputs are ignored when their handshake partner is low: INSTR_VALID outside IDLE, RES_VALID outside WAIT_RES, OPS_READY outside ISSUE.

## Timing
- Reset (synchronous): state←IDLE; OPA, OPB, RFWA, RFWD, RFWE←0; OPS_VALID=0; RES_READY=0.
  - INSTR_READY=1 from the first cycle after reset release.
  - RST has priority over every transition. Reset in WRITE deasserts RFWE on the next edge; a pending write-back is dropped.
- Latency, with acceptance at cycle 0:
  - READ in cycle 1; OPA/OPB valid and OPS_VALID=1 from cycle 2.
  - With zero wait from execute: result handshake in cycle 3, RFWE=1 in cycle 4, INSTR_READY=1 in cycle 5.
- OPS_VALID, OPA and OPB are held stable until OPS_READY. RES_READY is held until RES_VALID.
- RFRA1/RFRA2 reflect the latched instruction from READ onward and are stable through WRITE. They are 0 after reset.
- The block never issues a read and a write in the same cycle. The register file's read-first ordering is therefore irrelevant, and no forwarding is required.

## Structure
- Shared package `mips_pkg`: opcode/funct localparams (OP_RTYPE, OP_JAL, OP_LW, OP_SW, FN_JR, …), REG_RA=31, REG_ZERO=0, and the FSM state encoding.
- One sub-module, `rf_dest_decode`: combinational mapping from instruction to {writes, dest}. It is unit-testable in isolation.

## Test plan
- Register file preloaded r1=5, r2=7. `add $3,$1,$2` (0x00221820) → OPA=5, OPB=7 at cycle 2. RES_DATA=12 → one cycle of RFWE=1 with RFWA=3, RFWD=12; next cycle INSTR_READY=1.
- mem[0]=0xDEADBEEF. `addi $0,$0,4` (0x20000004) → OPA=0. Result accepted, RFWE never asserts.
- `jal` (0x0C000010), result 0x00400008 → RFWA=31, RFWD=0x00400008. `sw` (0xAC220000) and `jr $31` (0x03E00008) → result accepted, no RFWE.
- OPS_READY held low 3 cycles in ISSUE, with RES_VALID pulsed meanwhile → OPS_VALID stays high, OPA/OPB unchanged, RES pulse ignored. The write follows only the later RES handshake.
- INSTR_VALID held high during WAIT_RES with a different word → not accepted. The original instruction's destination is used.
- RST pulsed in WAIT_RES and separately in WRITE → next cycle state IDLE, RFWE=0, OPS_VALID=0, no further write for that instruction.
